// File: rtl/pit_table_pkg.sv
// Shared widths, FSM state type, table entry layout and prefix masking for the PIT stage.
// No logic of its own; the function is purely combinational.
// Not applicable: no handshakes live here.
package pit_pkg;

    localparam int PIT_ENTRIES  = 8;
    localparam int PIT_PREFIX_W = 64;
    localparam int PIT_LEN_W    = 6;
    localparam int PIT_FACE_W   = 3;
    localparam int PIT_FACE_N   = 1 << PIT_FACE_W;
    localparam int PIT_LIFETIME = 1000;
    localparam int PIT_LIFE_W   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Stored prefixes are always pre-masked so the compare is a plain equality.
    typedef struct packed {
        logic                    vld;
        logic [PIT_PREFIX_W-1:0] prefix;
        logic [PIT_LEN_W-1:0]    len;
        logic [PIT_FACE_N-1:0]   mask;
        logic [PIT_LIFE_W-1:0]   life;
    } pit_entry_t;

    // Keeps the top len bits; a shift by the full width (len 0) yields all zeros.
    function automatic logic [PIT_PREFIX_W-1:0] prefix_mask(input logic [PIT_LEN_W-1:0] len);
        return {PIT_PREFIX_W{1'b1}} << (PIT_PREFIX_W - int'(len));
    endfunction

endpackage

// File: rtl/pit_table_if.sv
// Bundles the interest input, the fib forward path and the fib return/response path.
// Wiring only, zero latency.
// Only the interest side handshakes (valid/ready); the fib return path has no backpressure.
interface pit_table_if
    import pit_pkg::*;
#(
    parameter int PREFIX_W = PIT_PREFIX_W,
    parameter int LEN_W    = PIT_LEN_W,
    parameter int FACE_W   = PIT_FACE_W
);
    logic                     interest_valid;
    logic [PREFIX_W-1:0]      interest_prefix;
    logic [LEN_W-1:0]         interest_len;
    logic [FACE_W-1:0]        interest_face;
    logic                     interest_ready;
    logic [PREFIX_W-1:0]      pit_in_prefix;
    logic [LEN_W-1:0]         pit_in_len;
    logic                     fib_out_bit;
    logic [PREFIX_W-1:0]      pit_out_prefix;
    logic [LEN_W-1:0]         pit_out_len;
    logic                     prefix_ready;
    logic                     start_send_to_pit;
    logic                     rejected;
    logic [(1<<FACE_W)-1:0]   face_mask;
    logic                     interest_drop;
    logic                     data_overflow;

    modport master (
        output interest_valid, interest_prefix, interest_len, interest_face,
        output pit_out_prefix, pit_out_len, prefix_ready,
        input  interest_ready, pit_in_prefix, pit_in_len, fib_out_bit,
        input  start_send_to_pit, rejected, face_mask, interest_drop, data_overflow
    );

    modport slave (
        input  interest_valid, interest_prefix, interest_len, interest_face,
        input  pit_out_prefix, pit_out_len, prefix_ready,
        output interest_ready, pit_in_prefix, pit_in_len, fib_out_bit,
        output start_send_to_pit, rejected, face_mask, interest_drop, data_overflow
    );
endinterface

// File: rtl/pit_table_match.sv
// Parallel compare of a masked key against every table entry plus a lowest-free-slot finder.
// Purely combinational, zero latency.
// No flow control; results are consumed by the owning FSM in its LOOKUP cycle.
module pit_match
    import pit_pkg::*;
#(
    parameter int ENTRIES  = PIT_ENTRIES,
    parameter int PREFIX_W = PIT_PREFIX_W,
    parameter int LEN_W    = PIT_LEN_W,
    parameter int IDX_W    = $clog2(PIT_ENTRIES)
) (
    input  logic [ENTRIES-1:0]  tbl_vld,
    input  logic [PREFIX_W-1:0] tbl_prefix [ENTRIES],
    input  logic [LEN_W-1:0]    tbl_len    [ENTRIES],
    input  logic [PREFIX_W-1:0] key_prefix,
    input  logic [LEN_W-1:0]    key_len,
    output logic [ENTRIES-1:0]  hit_vec,
    output logic                hit,
    output logic [IDX_W-1:0]    hit_idx,
    output logic                free_vld,
    output logic [IDX_W-1:0]    free_idx
);

    // Walk from the top index down so the lowest matching/free index is the last one written.
    always_comb begin
        hit_vec  = '0;
        hit      = 1'b0;
        hit_idx  = '0;
        free_vld = 1'b0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (tbl_vld[i] && (tbl_len[i] == key_len) && (tbl_prefix[i] == key_prefix)) begin
                hit_vec[i] = 1'b1;
                hit        = 1'b1;
                hit_idx    = IDX_W'(i);
            end
            if (!tbl_vld[i]) begin
                free_vld = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pit_table.sv
// Pending Interest Table: collapses duplicate interests, forwards misses to fib, answers fib returns.
// Request captured at edge N resolves at N+1; result pulses are high for the N+1..N+2 cycle; 1 request per 3 cycles.
// Interests are stalled via interest_ready; fib returns are never stalled, one is buffered and a second is dropped with data_overflow.
module pit_table
    import pit_pkg::*;
#(
    parameter int ENTRIES  = PIT_ENTRIES,
    parameter int PREFIX_W = PIT_PREFIX_W,
    parameter int LEN_W    = PIT_LEN_W,
    parameter int FACE_W   = PIT_FACE_W,
    parameter int LIFETIME = PIT_LIFETIME,
    parameter int LIFE_W   = PIT_LIFE_W
) (
    input  logic         clk,
    input  logic         rst,
    pit_table_if.slave   pit
);

    localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int FACE_N = 1 << FACE_W;

    state_t              state;
    pit_entry_t          tbl [ENTRIES];

    logic                hold_vld;
    logic [PREFIX_W-1:0] hold_prefix;
    logic [LEN_W-1:0]    hold_len;

    logic                req_data;
    logic [PREFIX_W-1:0] req_prefix;
    logic [LEN_W-1:0]    req_len;
    logic [FACE_W-1:0]   req_face;

    logic [ENTRIES-1:0]  tbl_vld;
    logic [PREFIX_W-1:0] tbl_prefix [ENTRIES];
    logic [LEN_W-1:0]    tbl_len    [ENTRIES];
    logic [ENTRIES-1:0]  hit_vec;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic                free_vld;
    logic [IDX_W-1:0]    free_idx;
    logic [FACE_N-1:0]   face_bit;
    logic                in_rdy;

    // Interests wait whenever fib data is pending so data never loses arbitration.
    assign in_rdy             = (state == IDLE) && !hold_vld && !pit.prefix_ready && !rst;
    assign pit.interest_ready = in_rdy;
    assign face_bit           = FACE_N'(1) << req_face;

    // Flatten the compare-relevant entry fields for the matcher.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            tbl_vld[i]    = tbl[i].vld;
            tbl_prefix[i] = tbl[i].prefix;
            tbl_len[i]    = tbl[i].len;
        end
    end

    pit_match #(
        .ENTRIES  (ENTRIES),
        .PREFIX_W (PREFIX_W),
        .LEN_W    (LEN_W),
        .IDX_W    (IDX_W)
    ) u_match (
        .tbl_vld    (tbl_vld),
        .tbl_prefix (tbl_prefix),
        .tbl_len    (tbl_len),
        .key_prefix (req_prefix),
        .key_len    (req_len),
        .hit_vec    (hit_vec),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .free_vld   (free_vld),
        .free_idx   (free_idx)
    );

    // FSM, table aging/updates, holding register and registered result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            hold_vld              <= 1'b0;
            hold_prefix           <= '0;
            hold_len              <= '0;
            req_data              <= 1'b0;
            req_prefix            <= '0;
            req_len               <= '0;
            req_face              <= '0;
            pit.fib_out_bit       <= 1'b0;
            pit.pit_in_prefix     <= '0;
            pit.pit_in_len        <= '0;
            pit.start_send_to_pit <= 1'b0;
            pit.rejected          <= 1'b0;
            pit.face_mask         <= '0;
            pit.interest_drop     <= 1'b0;
            pit.data_overflow     <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            pit.fib_out_bit       <= 1'b0;
            pit.pit_in_prefix     <= '0;
            pit.pit_in_len        <= '0;
            pit.start_send_to_pit <= 1'b0;
            pit.rejected          <= 1'b0;
            pit.face_mask         <= '0;
            pit.interest_drop     <= 1'b0;
            pit.data_overflow     <= 1'b0;

            // Aging first; hit handling below overrides an expiry on the same entry.
            for (int i = 0; i < ENTRIES; i++) begin
                if (tbl[i].vld) begin
                    tbl[i].life <= tbl[i].life - 1'b1;
                    if (tbl[i].life <= LIFE_W'(1)) begin
                        tbl[i].vld <= 1'b0;
                    end
                end
            end

            // Returns arriving while busy go to the single-entry holding register.
            if ((state != IDLE) && pit.prefix_ready) begin
                if (!hold_vld) begin
                    hold_vld    <= 1'b1;
                    hold_prefix <= pit.pit_out_prefix;
                    hold_len    <= pit.pit_out_len;
                end else begin
                    pit.data_overflow <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (hold_vld) begin
                        req_data    <= 1'b1;
                        req_prefix  <= hold_prefix & prefix_mask(hold_len);
                        req_len     <= hold_len;
                        // A live return arriving as the buffer drains refills it.
                        hold_vld    <= pit.prefix_ready;
                        hold_prefix <= pit.pit_out_prefix;
                        hold_len    <= pit.pit_out_len;
                        state       <= LOOKUP;
                    end else if (pit.prefix_ready) begin
                        req_data   <= 1'b1;
                        req_prefix <= pit.pit_out_prefix & prefix_mask(pit.pit_out_len);
                        req_len    <= pit.pit_out_len;
                        state      <= LOOKUP;
                    end else if (pit.interest_valid && in_rdy) begin
                        req_data   <= 1'b0;
                        req_prefix <= pit.interest_prefix & prefix_mask(pit.interest_len);
                        req_len    <= pit.interest_len;
                        req_face   <= pit.interest_face;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    state <= RESP;
                    if (req_data) begin
                        if (hit) begin
                            pit.start_send_to_pit <= 1'b1;
                            pit.face_mask         <= tbl[hit_idx].mask;
                            for (int i = 0; i < ENTRIES; i++) begin
                                if (hit_vec[i]) tbl[i].vld <= 1'b0;
                            end
                        end else begin
                            pit.rejected <= 1'b1;
                        end
                    end else if (hit) begin
                        for (int i = 0; i < ENTRIES; i++) begin
                            if (hit_vec[i]) begin
                                tbl[i].vld  <= 1'b1;
                                tbl[i].mask <= tbl[i].mask | face_bit;
                                tbl[i].life <= LIFE_W'(LIFETIME);
                            end
                        end
                    end else if (free_vld) begin
                        tbl[free_idx] <= '{vld: 1'b1, prefix: req_prefix, len: req_len,
                                           mask: face_bit, life: LIFE_W'(LIFETIME)};
                        pit.fib_out_bit   <= 1'b1;
                        pit.pit_in_prefix <= req_prefix;
                        pit.pit_in_len    <= req_len;
                    end else begin
                        pit.interest_drop <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pit_table.sv
// Scoreboarded bench for pit_table: two instances (default lifetime and LIFETIME=20).
// Stimulus pushes expected events; a negedge monitor pops and compares every output pulse.
// Also checks quiet-output rules and reset behaviour.
module tb_pit_table;

    typedef struct packed {
        logic [2:0]  kind;
        logic [63:0] prefix;
        logic [5:0]  len;
        logic [7:0]  mask;
    } ev_t;

    localparam logic [2:0] EV_FIB  = 3'd1;
    localparam logic [2:0] EV_SEND = 3'd2;
    localparam logic [2:0] EV_REJ  = 3'd3;
    localparam logic [2:0] EV_DROP = 3'd4;
    localparam logic [2:0] EV_OVF  = 3'd5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  qa[$];
    ev_t  qb[$];

    always #5 clk = ~clk;

    pit_table_if a ();
    pit_table_if b ();

    pit_table dut_a (.clk(clk), .rst(rst), .pit(a));
    pit_table #(.LIFETIME(20)) dut_b (.clk(clk), .rst(rst), .pit(b));

    function automatic ev_t mk(input logic [2:0] k, input logic [63:0] p, input logic [5:0] l,
                               input logic [7:0] m);
        ev_t e;
        e.kind = k; e.prefix = p; e.len = l; e.mask = m;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input bit sel, input ev_t e);
        if (sel) qb.push_back(e); else qa.push_back(e);
    endtask

    task automatic match_ev(input bit sel, input ev_t act);
        ev_t e;
        bit  have;
        string nm;
        nm   = sel ? "dut_b" : "dut_a";
        have = sel ? (qb.size() != 0) : (qa.size() != 0);
        n_checks++;
        if (!have) begin
            n_fail++;
            $display("FAIL %s unexpected event: kind=%0d prefix=%h len=%0d mask=%h",
                     nm, act.kind, act.prefix, act.len, act.mask);
        end else begin
            if (sel) e = qb.pop_front(); else e = qa.pop_front();
            if (e !== act) begin
                n_fail++;
                $display("FAIL %s event: got kind=%0d prefix=%h len=%0d mask=%h expected kind=%0d prefix=%h len=%0d mask=%h",
                         nm, act.kind, act.prefix, act.len, act.mask, e.kind, e.prefix, e.len, e.mask);
            end
        end
    endtask

    task automatic observe(input bit sel, input logic fob, input logic [63:0] pin, input logic [5:0] plen,
                           input logic ssp, input logic rej, input logic [7:0] fmask,
                           input logic drop, input logic ovf);
        if (ovf) match_ev(sel, mk(EV_OVF, 64'h0, 6'd0, 8'h0));
        if (fob) match_ev(sel, mk(EV_FIB, pin, plen, 8'h0));
        else     chk(sel ? "b_pit_in_quiet" : "a_pit_in_quiet", pin | {58'b0, plen}, 64'h0);
        if (ssp) match_ev(sel, mk(EV_SEND, 64'h0, 6'd0, fmask));
        else     chk(sel ? "b_face_mask_quiet" : "a_face_mask_quiet", {56'b0, fmask}, 64'h0);
        if (rej)  match_ev(sel, mk(EV_REJ, 64'h0, 6'd0, 8'h0));
        if (drop) match_ev(sel, mk(EV_DROP, 64'h0, 6'd0, 8'h0));
    endtask

    // Monitor: every output pulse must match the next expected event of its instance.
    always @(negedge clk) begin
        if (mon_en) begin
            observe(1'b0, a.fib_out_bit, a.pit_in_prefix, a.pit_in_len, a.start_send_to_pit,
                    a.rejected, a.face_mask, a.interest_drop, a.data_overflow);
            observe(1'b1, b.fib_out_bit, b.pit_in_prefix, b.pit_in_len, b.start_send_to_pit,
                    b.rejected, b.face_mask, b.interest_drop, b.data_overflow);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer an interest and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send_interest(input bit sel, input logic [63:0] p, input logic [5:0] l,
                                 input logic [2:0] f);
        bit rdy;
        rdy = 1'b0;
        if (sel) begin
            b.interest_valid = 1'b1; b.interest_prefix = p; b.interest_len = l; b.interest_face = f;
        end else begin
            a.interest_valid = 1'b1; a.interest_prefix = p; a.interest_len = l; a.interest_face = f;
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            rdy = sel ? b.interest_ready : a.interest_ready;
            if (rdy) break;
        end
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL interest_accept_timeout: got ready=0 expected ready=1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        if (sel) b.interest_valid = 1'b0; else a.interest_valid = 1'b0;
    endtask

    task automatic send_data(input bit sel, input logic [63:0] p, input logic [5:0] l);
        if (sel) begin
            b.prefix_ready = 1'b1; b.pit_out_prefix = p; b.pit_out_len = l;
        end else begin
            a.prefix_ready = 1'b1; a.pit_out_prefix = p; a.pit_out_len = l;
        end
        @(posedge clk);
        #1;
        if (sel) b.prefix_ready = 1'b0; else a.prefix_ready = 1'b0;
    endtask

    initial begin
        a.interest_valid = 1'b0; a.interest_prefix = '0; a.interest_len = '0; a.interest_face = '0;
        a.pit_out_prefix = '0; a.pit_out_len = '0; a.prefix_ready = 1'b0;
        b.interest_valid = 1'b0; b.interest_prefix = '0; b.interest_len = '0; b.interest_face = '0;
        b.pit_out_prefix = '0; b.pit_out_len = '0; b.prefix_ready = 1'b0;

        // Reset for 5 cycles; outputs must be quiet and interest_ready low.
        rst = 1'b1;
        idle(2);
        mon_en = 1'b1;
        idle(3);
        @(negedge clk);
        chk("ready_in_reset", {63'b0, a.interest_ready}, 64'h0);
        chk("pulses_in_reset", {58'b0, a.fib_out_bit, a.start_send_to_pit, a.rejected,
                                a.interest_drop, a.data_overflow, b.fib_out_bit}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("a_ready_after_reset", {63'b0, a.interest_ready}, 64'h1);
        chk("b_ready_after_reset", {63'b0, b.interest_ready}, 64'h1);
        idle(1);

        // 1: first interest forwarded with the masked prefix (top 10 bits are zero).
        expect_ev(0, mk(EV_FIB, 64'h0, 6'd10, 8'h0));
        send_interest(0, 64'h0000FFFF0000FFFF, 6'd10, 3'd2);
        idle(4);

        // 2: duplicate from face 5 collapses; data returns both faces and frees the entry.
        send_interest(0, 64'h0000FFFF0000FFFF, 6'd10, 3'd5);
        idle(4);
        expect_ev(0, mk(EV_SEND, 64'h0, 6'd0, 8'b00100100));
        send_data(0, 64'h0000FFFF0000FFFF, 6'd10);
        idle(4);
        expect_ev(0, mk(EV_REJ, 64'h0, 6'd0, 8'h0));
        send_data(0, 64'h0000FFFF0000FFFF, 6'd10);
        idle(4);

        // 3: data against an empty table.
        expect_ev(0, mk(EV_REJ, 64'h0, 6'd0, 8'h0));
        send_data(0, 64'hFFFF000000000000, 6'd16);
        idle(4);

        // 4: fill all 8 entries, the 9th is dropped, then entry 0x03 still answers.
        for (int i = 1; i <= 8; i++) begin
            expect_ev(0, mk(EV_FIB, {8'(i), 56'h0}, 6'd8, 8'h0));
            send_interest(0, {8'(i), 56'h0}, 6'd8, 3'(i));
        end
        expect_ev(0, mk(EV_DROP, 64'h0, 6'd0, 8'h0));
        send_interest(0, {8'h09, 56'h0}, 6'd8, 3'd1);
        idle(4);
        expect_ev(0, mk(EV_SEND, 64'h0, 6'd0, 8'h08));
        send_data(0, {8'h03, 56'h0}, 6'd8);
        idle(4);

        // 6: interest in flight, two returns arrive in LOOKUP and RESP: first held, second overflows.
        expect_ev(0, mk(EV_FIB, {8'h0A, 56'h0}, 6'd8, 8'h0));
        expect_ev(0, mk(EV_OVF, 64'h0, 6'd0, 8'h0));
        expect_ev(0, mk(EV_SEND, 64'h0, 6'd0, 8'h02));
        send_interest(0, {8'h0A, 56'hFF}, 6'd8, 3'd1);
        send_data(0, {8'h0A, 56'h0}, 6'd8);
        send_data(0, {8'h05, 56'h0}, 6'd8);
        idle(6);

        // 5: short-lifetime instance; a fresh entry answers, an aged one does not.
        expect_ev(1, mk(EV_FIB, {8'hCD, 56'h0}, 6'd8, 8'h0));
        expect_ev(1, mk(EV_SEND, 64'h0, 6'd0, 8'h10));
        send_interest(1, {8'hCD, 56'h1234}, 6'd8, 3'd4);
        idle(4);
        send_data(1, {8'hCD, 56'h0}, 6'd8);
        idle(4);
        expect_ev(1, mk(EV_FIB, {8'hAB, 56'h0}, 6'd8, 8'h0));
        expect_ev(1, mk(EV_REJ, 64'h0, 6'd0, 8'h0));
        send_interest(1, {8'hAB, 56'h0}, 6'd8, 3'd0);
        idle(25);
        send_data(1, {8'hAB, 56'h0}, 6'd8);
        idle(6);

        // Reset mid-operation: in-flight interest yields no pulse and the table is cleared.
        send_interest(0, {8'h0B, 56'h0}, 6'd8, 3'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_low_in_midreset", {63'b0, a.interest_ready}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        expect_ev(0, mk(EV_REJ, 64'h0, 6'd0, 8'h0));
        send_data(0, {8'h01, 56'h0}, 6'd8);

        // Drain outstanding expectations with a bounded wait.
        for (int k = 0; k < 100; k++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(posedge clk);
        end
        idle(3);
        chk("a_queue_drained", 64'(qa.size()), 64'h0);
        chk("b_queue_drained", 64'(qb.size()), 64'h0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/pit_table.md
# pit_table

Pending Interest Table stage sitting directly upstream of `fib`. It records incoming interests in a small fully-associative table and collapses duplicates. New misses are forwarded to `fib` on its `pit_in_*`/`fib_out_bit` inputs. It consumes `fib`'s returned prefixes (`pit_out_prefix`/`pit_out_len`/`prefix_ready`) and answers each with either `start_send_to_pit` plus a destination face mask, or `rejected`.

## Interface

**Parameters**
- `ENTRIES`, 8: table depth.
- `PREFIX_W`, 64: prefix width.
- `LEN_W`, 6: prefix-length width.
- `FACE_W`, 3: face ID width. The face mask is 2**FACE_W bits.
- `LIFETIME`, 1000: entry lifetime, in cycles.
- `LIFE_W`, 16: lifetime counter width.

**Ports**
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `interest_valid`  in  1  interest offered.
- `interest_prefix`  in  PREFIX_W  interest name, left-aligned.
- `interest_len`  in  LEN_W  significant bits of `interest_prefix`.
- `interest_face`  in  FACE_W  arrival face.
- `interest_ready`  out  1  interest accepted when high together with `interest_valid`.
- `pit_in_prefix`  out  PREFIX_W  masked prefix to `fib`.
- `pit_in_len`  out  LEN_W  length to `fib`.
- `fib_out_bit`  out  1  one-cycle forward strobe to `fib`.
- `pit_out_prefix`  in  PREFIX_W  prefix returned from `fib`.
- `pit_out_len`  in  LEN_W  returned length.
- `prefix_ready`  in  1  one-cycle strobe. No backpressure.
- `start_send_to_pit`  out  1  one-cycle pulse: returned prefix matched.
- `rejected`  out  1  one-cycle pulse: returned prefix unmatched.
- `face_mask`  out  2**FACE_W  faces to deliver to. Valid with `start_send_to_pit`, otherwise 0.
- `interest_drop`  out  1  one-cycle pulse: miss with table full.
- `data_overflow`  out  1  one-cycle pulse: `prefix_ready` lost.

## Operation

**Entry contents**
- Each entry holds: valid, masked prefix, len, face mask, lifetime counter.

**Masking and match**
- Masked prefix = prefix AND (~0 << (PREFIX_W − len)). len = 0 gives an all-zero mask.
- A hit requires entry valid, equal len, and equal masked prefix.

**State machine: IDLE → LOOKUP → RESP → IDLE**
- IDLE: if a data request is pending (holding register or live `prefix_ready`), capture it. Else, if `interest_valid && interest_ready`, capture the interest. Data has priority.
- LOOKUP: the compare runs against all entries. The hit vector and the lowest-index free entry are resolved combinationally. Results are registered at the exiting edge.

**Interest outcomes**
- Hit: OR the face bit into the entry's mask and reload its lifetime to `LIFETIME`. No forward.
- Miss with a free entry: allocate the lowest-index free entry with mask = 1<<face and lifetime = `LIFETIME`. Pulse `fib_out_bit` with `pit_in_prefix`/`pit_in_len` set to the masked prefix and len.
- Miss with table full: pulse `interest_drop`. The table is unchanged.

**Data outcomes**
- Hit: pulse `start_send_to_pit`, drive `face_mask` = entry mask, and invalidate the entry.
- Miss: pulse `rejected`.

**Data capture and overflow**
- `prefix_ready` in any state other than IDLE is latched into a one-deep holding register.
- A second `prefix_ready` while the register is full is discarded and pulses `data_overflow`.

**Lifetime**
- Every valid entry decrements its lifetime each cycle. At 0 the entry is invalidated.
- If expiry and a data hit or interest hit land on the same entry in the same cycle, the hit wins.

**Interest readiness**
- `interest_ready` = (state == IDLE) && holding register empty && !`prefix_ready` && !`rst`.

## Timing

- **Reset values:** all outputs 0. The table is all-invalid, the holding register is empty, and the state is IDLE. `interest_ready` rises the first cycle after `rst` falls.
- **Pulse timing:** a request captured at edge N is resolved at edge N+1. The pulse outputs are high for exactly the cycle between edges N+1 and N+2.
- **Throughput:** one request per 3 cycles.
- **Stable outputs:** `pit_in_prefix`/`pit_in_len` are 0 except while `fib_out_bit` is high.
- **Reset mid-operation:** an in-flight request is discarded. No pulse is emitted after the reset edge.

## Structure

- **`pit_pkg`:** width parameters, state enum (`IDLE`, `LOOKUP`, `RESP`), the `pit_entry_t` struct, and a mask function.
- **Sub-module `pit_match`:** combinational. Produces the masked compare across all entries, the one-hot hit vector, and the lowest-free-index priority encoder.

## Test plan

1. Reset 5 cycles, then interest prefix 64'h0000FFFF0000FFFF, len 10, face 2. Expect `fib_out_bit` for 1 cycle with `pit_in_prefix` = 0 and `pit_in_len` = 10.
2. Same interest from face 5. Expect no `fib_out_bit`. Then `prefix_ready` with the same prefix/len. Expect `start_send_to_pit` with `face_mask` = 8'b00100100, and the entry freed.
3. `prefix_ready` with 64'hFFFF000000000000, len 16, on an empty table. Expect a 1-cycle `rejected` and `face_mask` = 0.
4. Fill 8 distinct interests (len 8, prefixes 8'h01..8'h08 in the top byte); 8 `fib_out_bit` pulses. A 9th distinct interest gives `interest_drop`.
5. Set `LIFETIME` = 20. Insert one interest, wait 25 cycles, return the matching prefix. Expect `rejected`.
6. Interest in LOOKUP while `prefix_ready` arrives. The data is held and served next. A second `prefix_ready` in the same window pulses `data_overflow`.
